// File: rtl/text_row_scheduler_pkg.sv
// rtl/text_row_scheduler_pkg.sv - shared types and constants for the OLED text row scheduler
//
// Purpose: state encoding, row-source IDs, pixel address field positions,
// the row-map entry type and the glyph blank test used by the scheduler.
// Ports: none (package).
package text_row_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CHAR_WAIT = 2'd1,
        ST_FONT_WAIT = 2'd2,
        ST_OUTPUT    = 2'd3
    } state_t;

    localparam logic [1:0] SRC_UART     = 2'd0;
    localparam logic [1:0] SRC_BIN      = 2'd1;
    localparam logic [1:0] SRC_HEXDEC   = 2'd2;
    localparam logic [1:0] SRC_PROGRESS = 2'd3;

    // pixelAddress = {row[1:0], half, charIdx[3:0], column[2:0]}
    localparam int ADDR_COL_LSB  = 0;
    localparam int ADDR_COL_MSB  = 2;
    localparam int ADDR_CHAR_LSB = 3;
    localparam int ADDR_CHAR_MSB = 6;
    localparam int ADDR_HALF_BIT = 7;
    localparam int ADDR_ROW_LSB  = 8;
    localparam int ADDR_ROW_MSB  = 9;

    localparam logic [7:0] BLANK_THRESHOLD = 8'h20;

    typedef struct packed {
        logic [1:0] src;
        logic       raw;
    } row_map_t;

    // Control characters and the upper half of the code space have no glyph.
    function automatic logic is_blank(input logic [7:0] ch);
        return (ch < BLANK_THRESHOLD) || ch[7];
    endfunction

endpackage

// File: rtl/text_row_scheduler_row_map_regs.sv
// rtl/text_row_scheduler_row_map_regs.sv - 4-entry row-to-source configuration register file
//
// Purpose: holds {src, raw} for each of the four screen rows, with reset
// defaults rows 0..2 = sources 0..2 as text and row 3 = source 3 as raw.
// Ports:
//   clk, resetN            clock, async active-low reset
//   cfg_write              write enable; entry updates at the next clk edge
//   cfg_row/src/raw        entry index and new contents
//   rd_row, rd_entry       combinational read port
module row_map_regs
    import text_row_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       resetN,
    input  logic       cfg_write,
    input  logic [1:0] cfg_row,
    input  logic [1:0] cfg_src,
    input  logic       cfg_raw,
    input  logic [1:0] rd_row,
    output row_map_t   rd_entry
);

    row_map_t map_q [4];
    row_map_t map_d [4];

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            map_d[i] = map_q[i];
        end
        if (cfg_write) begin
            map_d[cfg_row] = '{src: cfg_src, raw: cfg_raw};
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            map_q[0] <= '{src: SRC_UART,     raw: 1'b0};
            map_q[1] <= '{src: SRC_BIN,      raw: 1'b0};
            map_q[2] <= '{src: SRC_HEXDEC,   raw: 1'b0};
            map_q[3] <= '{src: SRC_PROGRESS, raw: 1'b1};
        end else begin
            for (int i = 0; i < 4; i++) begin
                map_q[i] <= map_d[i];
            end
        end
    end

    assign rd_entry = map_q[rd_row];

endmodule

// File: rtl/text_row_scheduler.sv
// rtl/text_row_scheduler.sv - per-pixel-byte sequencer between screen driver, row sources and font ROM
//
// Purpose: accepts one pixel-byte request at a time, selects the mapped row
// source, waits out source and font latencies and returns one pixel byte.
// Ports:
//   clk, resetN                      clock, async active-low reset
//   pixelReq, pixelAddress           request from the screen driver
//   pixelData, pixelValid, busy      response and handshake
//   cfgWrite, cfgRow, cfgSrc, cfgRaw row-map configuration
//   charIndex, rowAddress, srcSel    drive to the row sources
//   srcByte0..srcByte3               row source outputs
//   fontAddr, fontData               external font ROM
module text_row_scheduler
    import text_row_scheduler_pkg::*;
#(
    parameter int CHAR_LATENCY = 2,
    parameter int FONT_LATENCY = 1
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       pixelReq,
    input  logic [9:0] pixelAddress,
    output logic [7:0] pixelData,
    output logic       pixelValid,
    output logic       busy,
    input  logic       cfgWrite,
    input  logic [1:0] cfgRow,
    input  logic [1:0] cfgSrc,
    input  logic       cfgRaw,
    output logic [3:0] charIndex,
    output logic [9:0] rowAddress,
    output logic [1:0] srcSel,
    input  logic [7:0] srcByte0,
    input  logic [7:0] srcByte1,
    input  logic [7:0] srcByte2,
    input  logic [7:0] srcByte3,
    output logic [10:0] fontAddr,
    input  logic [7:0] fontData
);

    localparam logic [2:0] CHAR_LAST = 3'(CHAR_LATENCY - 1);
    localparam logic [2:0] FONT_LAST = 3'(FONT_LATENCY - 1);

    state_t      state_q, state_d;
    logic [7:0]  pixel_data_q, pixel_data_d;
    logic [3:0]  char_index_q, char_index_d;
    logic [9:0]  row_address_q, row_address_d;
    logic [1:0]  src_sel_q, src_sel_d;
    logic        raw_q, raw_d;
    logic [7:0]  char_latch_q, char_latch_d;
    logic [10:0] font_addr_q, font_addr_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        latched_q, latched_d;

    row_map_t    map_entry;
    logic [7:0]  src_byte_sel;

    row_map_regs u_row_map (
        .clk       (clk),
        .resetN    (resetN),
        .cfg_write (cfgWrite),
        .cfg_row   (cfgRow),
        .cfg_src   (cfgSrc),
        .cfg_raw   (cfgRaw),
        .rd_row    (pixelAddress[ADDR_ROW_MSB:ADDR_ROW_LSB]),
        .rd_entry  (map_entry)
    );

    always_comb begin
        case (src_sel_q)
            SRC_UART:   src_byte_sel = srcByte0;
            SRC_BIN:    src_byte_sel = srcByte1;
            SRC_HEXDEC: src_byte_sel = srcByte2;
            default:    src_byte_sel = srcByte3;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        pixel_data_d  = pixel_data_q;
        char_index_d  = char_index_q;
        row_address_d = row_address_q;
        src_sel_d     = src_sel_q;
        raw_d         = raw_q;
        char_latch_d  = char_latch_q;
        font_addr_d   = font_addr_q;
        cnt_d         = cnt_q;
        latched_d     = latched_q;

        case (state_q)
            ST_IDLE: begin
                if (pixelReq) begin
                    row_address_d = pixelAddress;
                    char_index_d  = pixelAddress[ADDR_CHAR_MSB:ADDR_CHAR_LSB];
                    src_sel_d     = map_entry.src;
                    raw_d         = map_entry.raw;
                    cnt_d         = 3'd0;
                    latched_d     = 1'b0;
                    state_d       = ST_CHAR_WAIT;
                end
            end
            ST_CHAR_WAIT: begin
                // Two phases: count the source latency and latch the byte,
                // then classify the latched byte in the following cycle.
                if (!latched_q) begin
                    if (cnt_q == CHAR_LAST) begin
                        char_latch_d = src_byte_sel;
                        latched_d    = 1'b1;
                        cnt_d        = 3'd0;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (raw_q) begin
                    pixel_data_d = char_latch_q;
                    state_d      = ST_OUTPUT;
                end else if (is_blank(char_latch_q)) begin
                    pixel_data_d = 8'h00;
                    state_d      = ST_OUTPUT;
                end else begin
                    font_addr_d = {char_latch_q[6:0], row_address_q[ADDR_HALF_BIT],
                                   row_address_q[ADDR_COL_MSB:ADDR_COL_LSB]};
                    cnt_d       = 3'd0;
                    state_d     = ST_FONT_WAIT;
                end
            end
            ST_FONT_WAIT: begin
                if (cnt_q == FONT_LAST) begin
                    pixel_data_d = fontData;
                    state_d      = ST_OUTPUT;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q       <= ST_IDLE;
            pixel_data_q  <= 8'h00;
            char_index_q  <= 4'd0;
            row_address_q <= 10'd0;
            src_sel_q     <= 2'd0;
            raw_q         <= 1'b0;
            char_latch_q  <= 8'h00;
            font_addr_q   <= 11'd0;
            cnt_q         <= 3'd0;
            latched_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pixel_data_q  <= pixel_data_d;
            char_index_q  <= char_index_d;
            row_address_q <= row_address_d;
            src_sel_q     <= src_sel_d;
            raw_q         <= raw_d;
            char_latch_q  <= char_latch_d;
            font_addr_q   <= font_addr_d;
            cnt_q         <= cnt_d;
            latched_q     <= latched_d;
        end
    end

    assign pixelData  = pixel_data_q;
    assign pixelValid = (state_q == ST_OUTPUT);
    assign busy       = (state_q != ST_IDLE);
    assign charIndex  = char_index_q;
    assign rowAddress = row_address_q;
    assign srcSel     = src_sel_q;
    assign fontAddr   = font_addr_q;

endmodule

// File: tb/tb_text_row_scheduler.sv
// tb/tb_text_row_scheduler.sv - directed self-checking bench for text_row_scheduler
module tb_text_row_scheduler;

    logic        clk = 1'b0;
    logic        resetN;
    logic        pixelReq, pixelReq2;
    logic [9:0]  pixelAddress;
    logic        cfgWrite;
    logic [1:0]  cfgRow, cfgSrc;
    logic        cfgRaw;
    logic [7:0]  sb [4];
    logic [7:0]  fontData;

    logic [7:0]  pixelData, pixelData2;
    logic        pixelValid, pixelValid2, busy, busy2;
    logic [3:0]  charIndex, charIndex2;
    logic [9:0]  rowAddress, rowAddress2;
    logic [1:0]  srcSel, srcSel2;
    logic [10:0] fontAddr, fontAddr2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    text_row_scheduler dut (
        .clk(clk), .resetN(resetN), .pixelReq(pixelReq), .pixelAddress(pixelAddress),
        .pixelData(pixelData), .pixelValid(pixelValid), .busy(busy),
        .cfgWrite(cfgWrite), .cfgRow(cfgRow), .cfgSrc(cfgSrc), .cfgRaw(cfgRaw),
        .charIndex(charIndex), .rowAddress(rowAddress), .srcSel(srcSel),
        .srcByte0(sb[0]), .srcByte1(sb[1]), .srcByte2(sb[2]), .srcByte3(sb[3]),
        .fontAddr(fontAddr), .fontData(fontData)
    );

    text_row_scheduler #(.CHAR_LATENCY(1), .FONT_LATENCY(3)) dut2 (
        .clk(clk), .resetN(resetN), .pixelReq(pixelReq2), .pixelAddress(pixelAddress),
        .pixelData(pixelData2), .pixelValid(pixelValid2), .busy(busy2),
        .cfgWrite(cfgWrite), .cfgRow(cfgRow), .cfgSrc(cfgSrc), .cfgRaw(cfgRaw),
        .charIndex(charIndex2), .rowAddress(rowAddress2), .srcSel(srcSel2),
        .srcByte0(sb[0]), .srcByte1(sb[1]), .srcByte2(sb[2]), .srcByte3(sb[3]),
        .fontAddr(fontAddr2), .fontData(fontData)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request (cycle 0 = acceptance) and runs until the cycle
    // busy is low after pixelValid. The selected source shows `good` only in
    // cycle good_cyc (every cycle when good_cyc < 0), else 0x0A.
    task automatic run_req(input logic [9:0] addr, input int src, input logic [7:0] good,
                           input int good_cyc, input int extra_cyc, input bit use2,
                           output int vcyc, output logic [7:0] vdata, output int nvalid,
                           output int busy_first, output int busy_last);
        logic v, b;
        logic [7:0] d;
        vcyc = -1; vdata = 8'h00; nvalid = 0; busy_first = -1; busy_last = -1;
        sb[src] = (good_cyc < 0 || good_cyc == 0) ? good : 8'h0A;
        pixelAddress = addr;
        if (use2) pixelReq2 = 1'b1; else pixelReq = 1'b1;
        step();
        pixelReq = 1'b0; pixelReq2 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            v = use2 ? pixelValid2 : pixelValid;
            b = use2 ? busy2 : busy;
            d = use2 ? pixelData2 : pixelData;
            if (b) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
            end
            if (v) begin
                nvalid++;
                if (vcyc < 0) begin vcyc = c; vdata = d; end
            end
            if (vcyc >= 0 && !b) break;
            sb[src] = (good_cyc < 0 || good_cyc == c) ? good : 8'h0A;
            if (c == extra_cyc) begin
                if (use2) pixelReq2 = 1'b1; else pixelReq = 1'b1;
            end else begin
                pixelReq = 1'b0; pixelReq2 = 1'b0;
            end
            step();
        end
        pixelReq = 1'b0; pixelReq2 = 1'b0;
    endtask

    int vc, nv, bf, bl;
    logic [7:0] vd;
    bit seen;

    initial begin
        resetN = 1'b0; pixelReq = 1'b0; pixelReq2 = 1'b0; pixelAddress = '0;
        cfgWrite = 1'b0; cfgRow = '0; cfgSrc = '0; cfgRaw = 1'b0;
        fontData = 8'h7E;
        for (int i = 0; i < 4; i++) sb[i] = 8'h00;
        repeat (3) step();
        resetN = 1'b1;
        step();

        check("rst_pixelData", pixelData, 8'h00);
        check("rst_valid_busy", {pixelValid, busy}, 2'b00);
        check("rst_charIndex", charIndex, 4'd0);
        check("rst_rowAddress", rowAddress, 10'd0);
        check("rst_srcSel", srcSel, 2'd0);
        check("rst_fontAddr", fontAddr, 11'd0);

        // Default map, row0 text glyph
        run_req(10'h000, 0, 8'h41, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("txt_vcyc", vc, 5);
        check("txt_data", vd, 8'h7E);
        check("txt_fontAddr", fontAddr, 11'h410);
        check("txt_busy_first", bf, 1);
        check("txt_busy_last", bl, 5);
        check("txt_nvalid", nv, 1);

        // Raw row3
        run_req(10'h3A5, 3, 8'h0F, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("raw_vcyc", vc, 4);
        check("raw_data", vd, 8'h0F);
        check("raw_charIndex", charIndex, 4'd4);
        check("raw_rowAddress", rowAddress, 10'h3A5);
        check("raw_srcSel", srcSel, 2'd3);
        check("raw_fontAddr_kept", fontAddr, 11'h410);
        check("raw_data_hold", pixelData, 8'h0F);

        // Blank on row1: control char and high-bit char
        run_req(10'h100, 1, 8'h0A, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("blank_ctl_vcyc", vc, 4);
        check("blank_ctl_data", vd, 8'h00);
        run_req(10'h100, 1, 8'h80, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("blank_hi_vcyc", vc, 4);
        check("blank_hi_data", vd, 8'h00);
        check("blank_fontAddr_kept", fontAddr, 11'h410);

        // Remap row0 to src2 text, extra request while busy, then back-to-back
        cfgWrite = 1'b1; cfgRow = 2'd0; cfgSrc = 2'd2; cfgRaw = 1'b0;
        step();
        cfgWrite = 1'b0;
        fontData = 8'h5A;
        run_req(10'h000, 2, 8'h33, -1, 2, 1'b0, vc, vd, nv, bf, bl);
        check("remap_fontAddr", fontAddr, 11'h330);
        check("remap_srcSel", srcSel, 2'd2);
        check("remap_vcyc", vc, 5);
        check("remap_data", vd, 8'h5A);
        check("remap_nvalid", nv, 1);
        fontData = 8'hA5;
        run_req(10'h0A8, 2, 8'h48, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("b2b_vcyc", vc, 5);
        check("b2b_data", vd, 8'hA5);
        check("b2b_fontAddr", fontAddr, 11'h488);
        check("b2b_charIndex", charIndex, 4'd5);

        // srcByte sampling window on a raw row (CHAR_LATENCY = 2)
        run_req(10'h300, 3, 8'hC3, 2, 0, 1'b0, vc, vd, nv, bf, bl);
        check("win_exact", vd, 8'hC3);
        run_req(10'h300, 3, 8'hC3, 1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("win_early", vd, 8'h0A);
        run_req(10'h300, 3, 8'hC3, 3, 0, 1'b0, vc, vd, nv, bf, bl);
        check("win_late", vd, 8'h0A);

        // Reset in cycle 3 of a text request
        fontData = 8'h7E;
        sb[2] = 8'h41;
        pixelAddress = 10'h0A8; pixelReq = 1'b1;
        step();
        pixelReq = 1'b0;
        seen = 1'b0;
        for (int c = 1; c < 3; c++) begin
            if (pixelValid) seen = 1'b1;
            step();
        end
        resetN = 1'b0;
        #1;
        check("mrst_busy", busy, 1'b0);
        check("mrst_pixelData", pixelData, 8'h00);
        check("mrst_charIndex", charIndex, 4'd0);
        check("mrst_rowAddress", rowAddress, 10'd0);
        check("mrst_fontAddr", fontAddr, 11'd0);
        step();
        resetN = 1'b1;
        for (int c = 0; c < 8; c++) begin
            if (pixelValid) seen = 1'b1;
            step();
        end
        check("mrst_no_valid", seen, 1'b0);
        sb[0] = 8'h41;
        run_req(10'h000, 0, 8'h41, -1, 0, 1'b0, vc, vd, nv, bf, bl);
        check("post_rst_vcyc", vc, 5);
        check("post_rst_fontAddr", fontAddr, 11'h410);
        check("post_rst_data", vd, 8'h7E);

        // CHAR_LATENCY=1, FONT_LATENCY=3 instance
        run_req(10'h000, 0, 8'h41, -1, 0, 1'b1, vc, vd, nv, bf, bl);
        check("p2_txt_vcyc", vc, 6);
        check("p2_txt_data", vd, 8'h7E);
        check("p2_fontAddr", fontAddr2, 11'h410);
        run_req(10'h300, 3, 8'hC3, 1, 0, 1'b1, vc, vd, nv, bf, bl);
        check("p2_raw_vcyc", vc, 3);
        check("p2_win_exact", vd, 8'hC3);
        run_req(10'h300, 3, 8'hC3, 0, 0, 1'b1, vc, vd, nv, bf, bl);
        check("p2_win_early", vd, 8'h0A);
        run_req(10'h300, 3, 8'hC3, 2, 0, 1'b1, vc, vd, nv, bf, bl);
        check("p2_win_late", vd, 8'h0A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/text_row_scheduler.md
Name: text_row_scheduler

Overview:
- Sequences the four on-screen row sources (UART text, binary, hex/dec, progress bar) for the 128x64 OLED pixel stream.
- For each pixel-byte request from the screen driver it:
  - decodes the address;
  - selects the configured row source and drives its character index;
  - waits out the source latency;
  - fetches the glyph byte from the external font ROM (or bypasses it for raw-graphics rows);
  - returns one pixel byte with a valid pulse.
- Sits between the screen driver and the row modules/font ROM.

Parameters:
- CHAR_LATENCY, 2, cycles from charIndex change to stable srcByte (covers the slowest row source); range 1..7.
- FONT_LATENCY, 1, cycles from fontAddr change to stable fontData; range 1..7.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- pixelReq  in  1  single-cycle request for the byte at pixelAddress; accepted only when busy=0
- pixelAddress  in  10  {row[1:0], half, charIdx[3:0], column[2:0]}
- pixelData  out  8  rendered pixel byte (page format, LSB = top pixel)
- pixelValid  out  1  one-cycle pulse; pixelData valid in the same cycle
- busy  out  1  high from the acceptance cycle+1 until the pixelValid cycle inclusive
- cfgWrite  in  1  write one row-map entry
- cfgRow  in  2  row to configure
- cfgSrc  in  2  source: 0 uart text, 1 binary, 2 hex/dec, 3 progress (raw)
- cfgRaw  in  1  1 = source output is pixel data; bypass the font
- charIndex  out  4  character index to all row sources
- rowAddress  out  10  registered copy of the accepted pixelAddress (for raw sources)
- srcSel  out  2  selected source for the current request
- srcByte0..srcByte3  in  8 each  source outputs
- fontAddr  out  11  {srcByte[6:0], half, column[2:0]}
- fontData  in  8  font ROM output

Behaviour:
- Reset (async assert, sync release): state IDLE; pixelData 0, pixelValid 0, busy 0, charIndex 0, rowAddress 0, srcSel 0, fontAddr 0; counters 0.
- Reset row map: row0 = src0/text, row1 = src1/text, row2 = src2/text, row3 = src3/raw.
- Row map: 4 entries x {src[1:0], raw}. cfgWrite updates the entry at the next clk edge, in any state.
- The map is sampled at request acceptance. A write during a request affects only later requests. A write in the same cycle as acceptance is not seen by that request.
- State IDLE:
  - On pixelReq, register pixelAddress, srcSel, raw flag and charIndex = pixelAddress[6:3]; latency counter = 0.
  - Go to CHAR_WAIT. pixelReq while busy is ignored; no queueing.
- State CHAR_WAIT:
  - Count CHAR_LATENCY cycles, then sample srcByte[srcSel] into charLatch.
  - If raw: go to OUTPUT with pixelData = charLatch.
  - Else if charLatch < 0x20 or charLatch[7] = 1: go to OUTPUT with pixelData = 0x00 (blank, no font access).
  - Else: drive fontAddr and go to FONT_WAIT.
- State FONT_WAIT: count FONT_LATENCY cycles, then sample fontData into pixelData and go to OUTPUT.
- State OUTPUT: pixelValid = 1 for exactly one cycle, then IDLE. busy drops in the following cycle. The next pixelReq can be accepted in the IDLE cycle.
- Latency, acceptance cycle = 0:
  - Text glyph: pixelValid at cycle 2+CHAR_LATENCY+FONT_LATENCY (5 with defaults).
  - Raw or blank: pixelValid at cycle 2+CHAR_LATENCY (4).
- pixelData holds its last value between requests. charIndex, rowAddress and srcSel hold until the next acceptance.
- Reset asserted mid-request aborts immediately: no pixelValid; all outputs return to reset values.
- Counters are 3 bits, compare equal to parameter-1, with no wrap beyond the parameter.

Decomposition:
- Shared package:
  - state encoding (IDLE, CHAR_WAIT, FONT_WAIT, OUTPUT);
  - source IDs (SRC_UART=0, SRC_BIN=1, SRC_HEXDEC=2, SRC_PROGRESS=3);
  - address field positions;
  - blank threshold 0x20.
- One natural sub-module: row_map_regs, the 4-entry configuration register file with reset defaults and a read port indexed by row.

Test Plan:
- Reset defaults: after resetN release, pixelReq with pixelAddress=0x000, srcByte0=0x41, fontData=0x7E -> fontAddr={0x41,0,000}=0x410, pixelValid at cycle 5, pixelData=0x7E, busy high cycles 1..5.
- Raw path: pixelReq with pixelAddress=0x3A5 (row3, half1, char4, col5), srcByte3=0x0F -> charIndex=4, rowAddress=0x3A5, pixelValid at cycle 4 with pixelData=0x0F, fontAddr unchanged.
- Blank: row1 request, srcByte1=0x0A -> pixelData=0x00 at cycle 4. Repeat with srcByte1=0x80 -> same result.
- Remap plus busy ignore:
  - cfgWrite row0 <- src2/text; request row0 with srcByte2=0x33 -> fontAddr=0x330.
  - A second pixelReq at cycle 2 is ignored; exactly one pixelValid.
  - A back-to-back request accepted the cycle after busy falls completes normally.
- Mid-request reset: assert resetN=0 at cycle 3 of a text request -> no pixelValid, busy=0, pixelData=0. After release, the next request completes with nominal latency.
- Parameter sweep CHAR_LATENCY=1, FONT_LATENCY=3: text pixelValid at cycle 6. Also check srcByte is sampled exactly CHAR_LATENCY cycles after charIndex changes, by changing srcByte one cycle early or late and checking it is rejected.
